// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for the VGA timing source.
// The defaults describe the 640x480@60 mode; CNT_W sizes the raster counters.
package vga_timing_pkg;
  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bus_t;

  // Half-open window test: lo <= pos < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction
endpackage

// File: rtl/vga_timing_core_sync_delay_line.sv
// pix_ce-qualified shift register that realigns syncs/DE with the colour path.
// DEPTH=0 degenerates to a wire; reset loads every stage with the idle vector.
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, ce, rst_val};
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
        end else if (ce) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/vga_timing_core.sv
// Raster timing source: counters, sync/blank decodes, line/frame strobes and
// delayed sync/DE copies matching the registered colour path.
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int OUT_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             display_on,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_cnt,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam sync_bus_t IDLE = {~H_POL, ~V_POL, 1'b0};

  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             at_origin;
  sync_bus_t        raw_bus, dly_bus;

  // Decodes use the next-state position so every flop describes the same pixel.
  always_comb begin
    h_nxt = (hpos == H_LAST) ? '0 : hpos + 1'b1;
    v_nxt = vpos;
    if (hpos == H_LAST) v_nxt = (vpos == V_LAST) ? '0 : vpos + 1'b1;
    at_origin = (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      display_on  <= 1'b0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 16'hFFFF;
    end else if (pix_ce) begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      display_on  <= in_window(h_nxt, 0, H_ACTIVE) && in_window(v_nxt, 0, V_ACTIVE);
      hsync       <= in_window(h_nxt, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC) ? H_POL : ~H_POL;
      vsync       <= in_window(v_nxt, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC) ? V_POL : ~V_POL;
      line_start  <= (h_nxt == '0);
      frame_start <= at_origin;
      if (at_origin) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign raw_bus = {hsync, vsync, display_on};

  sync_delay_line #(
    .WIDTH (3),
    .DEPTH (OUT_DELAY)
  ) u_sync_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (pix_ce),
    .rst_val (IDLE),
    .d       (raw_bus),
    .q       (dly_bus)
  );

  assign {hsync_o, vsync_o, de_o} = dly_bus;
endmodule
